// File: rtl/bcd_conv_if.sv
// Bundles the field request/ack handshake, the engine start/done handshake
// and the per-field digit outputs of the BCD conversion scheduler.
// slave  : the scheduler side.
// master : the environment side (field requesters, engine, LCD writer).
interface bcd_conv_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*8-1:0]  bin_in;
    logic [NUM_REQ-1:0]    ack;
    logic                  conv_start;
    logic [7:0]            conv_bin;
    logic                  conv_done;
    logic [11:0]           conv_bcd;
    logic [NUM_REQ*12-1:0] bcd_out;
    logic [NUM_REQ-1:0]    bcd_valid;
    logic                  busy;
    logic                  timeout_err;

    modport slave (
        input  req, bin_in, conv_done, conv_bcd,
        output ack, conv_start, conv_bin, bcd_out, bcd_valid, busy, timeout_err
    );

    modport master (
        output req, bin_in, conv_done, conv_bcd,
        input  ack, conv_start, conv_bin, bcd_out, bcd_valid, busy, timeout_err
    );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one iterative binary-to-BCD engine between
// NUM_REQ display fields. Each field raises a level request; the winner's
// 8-bit value is handed to the engine, and the returned {H,T,O} digits are
// held per field for the LCD writer. A watchdog abandons a conversion the
// engine never completes and raises a sticky timeout_err.
//
// Optional build macro: SKIP_UNCHANGED_EN
//   When defined, a field re-requesting with the same value it last had
//   converted is acknowledged straight from the held digits without
//   running the engine.
module bcd_conv_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic      clk,
    input  logic      rst,
    bcd_conv_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_found;
    logic [IDX_W:0]        arb_res;
    logic [7:0]            arb_bin;

    logic [WD_W-1:0]       watchdog;
    logic                  wd_expire;
    logic                  skip_hit;

    logic [7:0]            conv_bin_q;
    logic [NUM_REQ*12-1:0] bcd_out_q;
    logic [NUM_REQ-1:0]    bcd_valid_q;
    logic                  timeout_err_q;

    logic [NUM_REQ-1:0]    ack_c;
    logic                  conv_start_c;
    logic                  busy_c;

    // First set request strictly after ptr, wrapping modulo NUM_REQ.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (r[idx]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    // Arbitration result and the candidate's operand, evaluated every cycle.
    always_comb begin
        arb_res   = rr_pick(bus.req, rr_ptr);
        arb_found = arb_res[IDX_W];
        arb_idx   = arb_res[IDX_W-1:0];
        arb_bin   = bus.bin_in[int'(arb_idx)*8 +: 8];
    end

`ifdef SKIP_UNCHANGED_EN
    logic [7:0]         last_bin [NUM_REQ];
    logic [NUM_REQ-1:0] seen;

    // Reuse held digits when the winner's value matches its last conversion.
    always_comb begin
        skip_hit = arb_found
                && bcd_valid_q[arb_idx]
                && seen[arb_idx]
                && (last_bin[arb_idx] == arb_bin);
    end

    // Remember the operand of every conversion the engine actually completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                last_bin[k] <= '0;
            end
            seen <= '0;
        end else if (state == WAIT && bus.conv_done) begin
            last_bin[grant_idx] <= conv_bin_q;
            seen[grant_idx]     <= 1'b1;
        end
    end
`else
    assign skip_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the per-state handshake outputs.
    always_comb begin
        state_nxt    = state;
        wd_expire    = 1'b0;
        ack_c        = '0;
        conv_start_c = 1'b0;
        busy_c       = (state != IDLE);
        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt = skip_hit ? STORE : ISSUE;
                end
            end
            ISSUE: begin
                conv_start_c = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                // A done arriving on the terminal watchdog cycle still wins.
                if (bus.conv_done) begin
                    state_nxt = STORE;
                end else if (watchdog == WD_W'(TIMEOUT_CYC - 1)) begin
                    wd_expire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            STORE: begin
                ack_c[grant_idx] = 1'b1;
                state_nxt        = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant latch, watchdog, digit storage, round-robin pointer and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            grant_idx     <= '0;
            conv_bin_q    <= '0;
            watchdog      <= '0;
            bcd_out_q     <= '0;
            bcd_valid_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_idx <= arb_idx;
                        // The engine is idle on a reuse, so its operand is left alone.
                        if (!skip_hit) begin
                            conv_bin_q <= arb_bin;
                        end
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                end
                WAIT: begin
                    watchdog <= watchdog + 1'b1;
                    // Digits land as STORE begins so they are readable alongside ack.
                    if (bus.conv_done) begin
                        bcd_out_q[int'(grant_idx)*12 +: 12] <= bus.conv_bcd;
                        bcd_valid_q[grant_idx]              <= 1'b1;
                    end else if (wd_expire) begin
                        timeout_err_q <= 1'b1;
                        rr_ptr        <= grant_idx;
                    end
                end
                STORE: begin
                    rr_ptr <= grant_idx;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ack         = ack_c;
    assign bus.conv_start  = conv_start_c;
    assign bus.conv_bin    = conv_bin_q;
    assign bus.bcd_out     = bcd_out_q;
    assign bus.bcd_valid   = bcd_valid_q;
    assign bus.busy        = busy_c;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
Time-shares one iterative binary-to-BCD conversion engine between NUM_REQ display fields on the LCD path (e.g. counter, temperature, setpoint). It takes per-field request/ack handshakes, grants them round-robin, drives the engine's start/done handshake and holds each field's latest hundreds/tens/ones digits for the LCD writer. A watchdog recovers the scheduler if the engine never returns done.

Parameters:
NUM_REQ, 4, number of requesting fields (2..8)
TIMEOUT_CYC, 32, cycles in WAIT before abort (must be > engine latency of 9)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-field conversion request; level, held until ack
bin_in  in  NUM_REQ*8  per-field 8-bit binary value; field k = bits [8k+7:8k]
ack  out  NUM_REQ  one-cycle pulse when field k's result is stored
conv_start  out  1  one-cycle start pulse to engine
conv_bin  out  8  operand to engine; stable from start until done
conv_done  in  1  engine one-cycle completion pulse
conv_bcd  in  12  engine result {H,T,O}, valid with conv_done
bcd_out  out  NUM_REQ*12  stored digits per field; field k = bits [12k+11:12k] = {H,T,O}
bcd_valid  out  NUM_REQ  field k holds at least one completed result
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on watchdog abort, cleared only by rst

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=NUM_REQ-1, grant_idx=0, ack=0, conv_start=0, conv_bin=0, bcd_out=0, bcd_valid=0, busy=0, timeout_err=0, watchdog=0.
- States: IDLE, ISSUE, WAIT, STORE.
- IDLE: if any req bit set, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ; latch grant_idx and conv_bin=bin_in[grant_idx]; -> ISSUE. Otherwise stay.
- ISSUE: conv_start=1 for exactly this cycle; watchdog cleared; -> WAIT.
- WAIT: watchdog increments each cycle. On conv_done: capture conv_bcd -> STORE. If watchdog reaches TIMEOUT_CYC-1 without done: set timeout_err, no ack, rr_ptr=grant_idx, -> IDLE. done on the terminal watchdog cycle wins over timeout.
- STORE: bcd_out[grant_idx]=captured value, bcd_valid[grant_idx]=1, ack[grant_idx]=1 for this cycle only, rr_ptr=grant_idx; -> IDLE.
- Latency single request, idle scheduler, engine latency L: req seen in IDLE cycle n, conv_start at n+1, ack at n+L+2 (conv_done at n+1+L, STORE next).
- Requester must drop req the cycle after ack; req still high in the following IDLE cycle is treated as a new request.
- bin_in sampled only at grant; later changes do not affect the conversion in flight.
- conv_done outside WAIT ignored. conv_bcd digits > 9 stored unchanged (no checking).
- Fairness: with all req high, grants cycle 0,1,..,NUM_REQ-1,0; no field waits more than NUM_REQ-1 other conversions.
- Unselected bcd_out fields never change except via their own STORE.

Optional Feature:
SKIP_UNCHANGED_EN: when defined, a per-field last-converted value register (reset 0, plus per-field seen flag) is kept. In IDLE, if the granted field has bcd_valid=1 and bin_in equals its last value, go straight to STORE reusing the held digits (no conv_start), ack 1 cycle after grant. When undefined, every grant runs the engine.

Test Plan:
- Reset then req[0]=1, bin_in[0]=8'd255, engine L=9 -> conv_start 1 cycle after req, conv_bin=255, ack[0] at +11, bcd_out[0]=12'h255, bcd_valid=4'b0001.
- All four req high, values 0,9,100,199 -> grant order 0,1,2,3; bcd_out = 12'h000,12'h009,12'h100,12'h199; exactly one ack per field.
- After field 1 served, req[1] and req[3] high together -> field 3 granted first (rr_ptr=1).
- Engine never asserts conv_done -> after TIMEOUT_CYC cycles in WAIT, timeout_err=1, no ack, busy=0; next request still served normally.
- rst asserted in WAIT mid-conversion -> all outputs zero immediately, late conv_done ignored, no ack.
- SKIP_UNCHANGED_EN defined: convert 8'd42, re-request same value -> no conv_start, ack 1 cycle after grant, bcd_out 12'h042; re-request 8'd43 -> engine runs.
